// File: rtl/mp_add_pkg.sv
// Shared types and sizing for the multi-precision add/subtract sequencer.
// Optional signed-overflow output is enabled by MP_ADD_OVF_EN.
package mp_add_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/csel_add16.sv
// 16-bit carry-select chunk adder: 2-bit ripple head,
// then select blocks of 2, 3, 4 and 5 bits.
module csel_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [2:0] r0;
  logic [2:0] p1, q1, s1;
  logic [3:0] p2, q2, s2;
  logic [4:0] p3, q3, s3;
  logic [5:0] p4, q4, s4;

  assign r0 = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b0, cin};

  // Each block precomputes both carry-in cases; the incoming carry picks one.
  assign p1 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign q1 = p1 + 3'd1;
  assign s1 = r0[2] ? q1 : p1;

  assign p2 = {1'b0, a[6:4]} + {1'b0, b[6:4]};
  assign q2 = p2 + 4'd1;
  assign s2 = s1[2] ? q2 : p2;

  assign p3 = {1'b0, a[10:7]} + {1'b0, b[10:7]};
  assign q3 = p3 + 5'd1;
  assign s3 = s2[3] ? q3 : p3;

  assign p4 = {1'b0, a[15:11]} + {1'b0, b[15:11]};
  assign q4 = p4 + 6'd1;
  assign s4 = s3[4] ? q4 : p4;

  assign sum  = {s4[4:0], s3[3:0], s2[2:0], s1[1:0], r0[1:0]};
  assign cout = s4[5];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract, one 16-bit chunk per cycle, LSB first.
// Define MP_ADD_OVF_EN to add the registered signed-overflow output ovf.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = CHUNK_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
`ifdef MP_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int            IW   = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t state, state_n;

  logic [IW-1:0]      idx;
  logic               carry;
  logic [W-1:0]       a_q, b_q;
  logic [CHUNK_W-1:0] ca, cb, cs;
  logic               cc;
  logic               last;

  assign ca   = a_q[int'(idx) * CHUNK_W +: CHUNK_W];
  assign cb   = b_q[int'(idx) * CHUNK_W +: CHUNK_W];
  assign last = (idx == LAST);

  csel_add16 u_add (
    .a    (ca),
    .b    (cb),
    .cin  (carry),
    .sum  (cs),
    .cout (cc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef MP_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        S_RUN: begin
          sum[int'(idx) * CHUNK_W +: CHUNK_W] <= cs;
          carry <= cc;
          // Park idx at 0 so it never points past the last chunk.
          idx   <= last ? '0 : idx + IW'(1);
          if (last) begin
            cout <= cc;
`ifdef MP_ADD_OVF_EN
            ovf  <= ca[CHUNK_W-1] ^ cb[CHUNK_W-1] ^ cs[CHUNK_W-1] ^ cc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (WORDS=4); ovf checks follow
// MP_ADD_OVF_EN.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef MP_ADD_OVF_EN
  logic         ovf;
`endif

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef MP_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic monitor();
    logic ov_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && !ov_q) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_out_valid: got 1 want 0");
          end else begin
            chk("latency", W'(cyc - sb[0].acc), W'(WORDS));
          end
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("sum", sum, e.s);
          chk("cout", W'(cout), W'(e.c));
`ifdef MP_ADD_OVF_EN
          chk("ovf", W'(ovf), W'(e.o));
`endif
        end
      end
      ov_q = rst_n && out_valid;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo, input bit push, output int acc);
    exp_t e;
    int   k;
    for (k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    in_valid = 1'b1;
    a = ai;
    b = bi;
    cin = ci;
    sub = si;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = ~ci;
    sub = ~si;
    acc = cyc;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.o = eo;
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", W'(sb.size()), W'(0));
  endtask

  int acc1, acc2;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1, acc1);
    wait_drain();
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0, 1'b1, 1'b0, 1'b1, acc1);
    wait_drain();
    do_op(64'h5, 64'h7, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, acc1);
    wait_drain();
    do_op(64'h7, 64'h5, 1'b1, 1'b1,
          64'h2, 1'b1, 1'b0, 1'b1, acc1);
    wait_drain();
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
          64'h2345_6789_ABCD_F002, 1'b0, 1'b0, 1'b1, acc1);
    wait_drain();
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, acc1);
    wait_drain();
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, acc1);
    wait_drain();

    // Backpressure: result held in DONE, new operands refused.
    out_ready = 1'b0;
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
          64'h0, 1'b1, 1'b1, 1'b1, acc1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom};
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_sum_stable", sum, 64'h0);
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_busy", W'(busy), W'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_in_ready", W'(in_ready), W'(1));
    chk("hs_out_valid", W'(out_valid), W'(0));
    chk("idle_sum_held", sum, 64'h0);
    wait_drain();

    // Back-to-back: accept, WORDS RUN cycles, DONE, IDLE, accept.
    do_op(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 1'b1, acc1);
    do_op(64'h3, 64'h4, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, acc2);
    chk("b2b_spacing", W'(acc2 - acc1), W'(WORDS + 2));
    wait_drain();

    // Reset while RUN is at idx=2; the result must be discarded.
    do_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0,
          64'h0, 1'b0, 1'b0, 1'b0, acc1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_sum", sum, '0);
    chk("mid_rst_busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_op(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b1, acc1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
